// File: rtl/alu_md_sequencer.sv
//==============================================================================
// Module   : alu_md_sequencer
// Purpose  : Multi-cycle unsigned shift-add multiply / restoring divide
//            sequencer driving an external 74S181 ALU slice chain.
// Options  : define ALU_MD_ABORT_EN to add the abort input port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_md_sequencer #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef ALU_MD_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin_n,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout_n
);

    // ALU control words packed as {S[3:0], M, CIN_N}
    localparam logic [5:0] C_ALU_PASS = {4'b0000, 1'b0, 1'b1};
    localparam logic [5:0] C_ALU_ADD  = {4'b1001, 1'b0, 1'b1};
    localparam logic [5:0] C_ALU_SUB  = {4'b0110, 1'b0, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL    = 3'd1,
        ST_DSHIFT = 3'd2,
        ST_DSUB   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic [5:0]       r_ctrl;
    logic             w_last;

    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign alu_a     = r_r;
    assign alu_b     = r_b;
    assign {alu_s, alu_m, alu_cin_n} = r_ctrl;
    assign result_hi = r_r;
    assign result_lo = r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_r      <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_ctrl   <= C_ALU_PASS;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ctrl <= C_ALU_PASS;
                    if (start) begin
                        r_b      <= b_in;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        if (!op_div) begin
                            r_r     <= '0;
                            r_q     <= a_in;
                            // Controls are registered, so pre-select for the first step
                            r_ctrl  <= a_in[0] ? C_ALU_ADD : C_ALU_PASS;
                            r_state <= ST_MUL;
                        end else if (b_in != '0) begin
                            r_r     <= '0;
                            r_q     <= a_in;
                            r_state <= ST_DSHIFT;
                        end else begin
                            r_r      <= a_in;
                            r_q      <= '1;
                            div_zero <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    r_r   <= {~alu_cout_n & r_q[0], alu_f[WIDTH-1:1]};
                    r_q   <= {alu_f[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_ctrl  <= C_ALU_PASS;
                        r_state <= ST_DONE;
                    end else begin
                        // r_q[1] becomes the next step's multiplier bit
                        r_ctrl  <= r_q[1] ? C_ALU_ADD : C_ALU_PASS;
                    end
                end
                ST_DSHIFT: begin
                    {r_ovf, r_r, r_q} <= {r_r, r_q, 1'b0};
                    r_ctrl  <= C_ALU_SUB;
                    r_state <= ST_DSUB;
                end
                ST_DSUB: begin
                    if (r_ovf || !alu_cout_n) begin
                        r_r    <= alu_f;
                        r_q[0] <= 1'b1;
                    end
                    r_cnt   <= r_cnt + CW'(1);
                    r_ctrl  <= C_ALU_PASS;
                    r_state <= w_last ? ST_DONE : ST_DSHIFT;
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ctrl  <= C_ALU_PASS;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef ALU_MD_ABORT_EN
            if (abort && (r_state == ST_MUL || r_state == ST_DSHIFT || r_state == ST_DSUB)) begin
                r_state  <= ST_IDLE;
                r_r      <= '0;
                r_q      <= '0;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
                r_ctrl   <= C_ALU_PASS;
                busy     <= 1'b0;
                div_zero <= 1'b0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_md_sequencer.sv
//==============================================================================
// Module   : tb_alu_md_sequencer
// Purpose  : Self-checking bench: 74S181 ripple chain model plus arithmetic
//            reference for multiply / divide results and latency.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_md_sequencer;

    localparam int WIDTH = 32;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             op_div = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
`ifdef ALU_MD_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] result_hi, result_lo, alu_a, alu_b, alu_f;
    logic [3:0]       alu_s;
    logic             alu_m, alu_cin_n, alu_cout_n;

    int errors = 0;
    int checks = 0;

    alu_md_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op_div     (op_div),
        .a_in       (a_in),
        .b_in       (b_in),
`ifdef ALU_MD_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_cin_n  (alu_cin_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_cout_n (alu_cout_n)
    );

    always #5 clk = ~clk;

    // 74S181 slices, active-high data, ripple carry between slices
    logic [3:0] t1, t2;
    logic [4:0] sum5;
    logic       carry;
    always_comb begin
        carry = ~alu_cin_n;
        alu_f = '0;
        t1    = '0;
        t2    = '0;
        sum5  = '0;
        for (int i = 0; i < WIDTH / 4; i++) begin
            t1 = alu_a[4*i +: 4] | (alu_b[4*i +: 4] & {4{alu_s[0]}}) | (~alu_b[4*i +: 4] & {4{alu_s[1]}});
            t2 = (alu_a[4*i +: 4] & ~alu_b[4*i +: 4] & {4{alu_s[2]}}) | (alu_a[4*i +: 4] & alu_b[4*i +: 4] & {4{alu_s[3]}});
            if (alu_m) begin
                alu_f[4*i +: 4] = ~(t1 ^ t2);
                sum5 = '0;
            end else begin
                sum5 = {1'b0, t1} + {1'b0, t2} + {4'b0, carry};
                alu_f[4*i +: 4] = sum5[3:0];
                carry = sum5[4];
            end
        end
        alu_cout_n = ~carry;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit div, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit poke);
        logic [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]   exp_hi, exp_lo;
        int                 lat, cyc;
        bit                 busy_bad;
        if (!div) begin
            prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            exp_hi = prod[2*WIDTH-1:WIDTH];
            exp_lo = prod[WIDTH-1:0];
            lat    = WIDTH + 1;
        end else if (b == '0) begin
            exp_hi = a;
            exp_lo = '1;
            lat    = 1;
        end else begin
            exp_hi = a % b;
            exp_lo = a / b;
            lat    = 2 * WIDTH + 1;
        end
        @(negedge clk);
        start = 1'b1; op_div = div; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        cyc = 0;
        busy_bad = 1'b0;
        do begin
            if (!busy) busy_bad = 1'b1;
            if (poke && cyc == 3) begin
                start = 1'b1; op_div = ~div;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 200);
        check("latency", cyc, lat);
        check("busy_during_op", busy_bad, 0);
        check("busy_at_done", busy, 0);
        check("result_hi", result_hi, exp_hi);
        check("result_lo", result_lo, exp_lo);
        check("div_zero", div_zero, (div && b == '0));
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);
        check("ctrl_idle", {alu_s, alu_m, alu_cin_n}, 6'b000001);
        check("result_hold_lo", result_lo, exp_lo);
    endtask

    // Starts a multiply, pokes start mid-op, then kills it after ten steps
    task automatic kill_test(input bit use_reset);
        bit seen_done;
        seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; a_in = $urandom | 32'h1; b_in = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        if (done) seen_done = 1'b1;
        if (use_reset) begin
            @(posedge clk); #1;
            reset_n = 1'b0;
            #1;
        end else begin
`ifdef ALU_MD_ABORT_EN
            @(negedge clk); abort = 1'b1;
            @(posedge clk); #1; abort = 1'b0;
`endif
        end
        check("kill_busy", busy, 0);
        check("kill_r", result_hi, 0);
        check("kill_q", result_lo, 0);
        check("kill_ctrl", {alu_s, alu_m, alu_cin_n}, 6'b000001);
        check("kill_div_zero", div_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("kill_no_done", seen_done, 0);
        check("kill_idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", result_hi, 0);
        check("rst_lo", result_lo, 0);
        check("rst_ctrl", {alu_s, alu_m, alu_cin_n}, 6'b000001);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(1'b0, 32'd3, 32'd5, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b1, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b1, 32'h1234, 32'd0, 1'b0);
        run_op(1'b0, 32'd0, 32'h1234_5678, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] ra, rb;
            bit               rd;
            rd = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = rd ? '0 : $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 255));
            run_op(rd, ra, rb, 1'($urandom_range(0, 1)));
        end

        kill_test(1'b1);
`ifdef ALU_MD_ABORT_EN
        kill_test(1'b0);
`endif
        run_op(1'b1, 32'd1000, 32'd33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
